instr_sequencer: RTL and testbench

- Control stage that consumes 80-bit instruction words from the 16-entry instruction bank.
- Drives the bank address, latches and decodes each word, and issues the operation plus constant to the complex ALU.
- Holds each operation for its programmed maximum latency, then pulses the register-file write enables.
- Sits between the instruction bank and the ALU/register-file datapath.

---
 rtl/instr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: steps through the 16-entry instruction bank, issues each word to the ALU,
// holds for its latency and strobes the register-file writes. SEQ_SINGLE_STEP_EN adds a step-gated PAUSE.
module instr_sequencer #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned LAST_ADDR = 15,
    parameter logic [3:0]  HALT_OPR  = 4'hF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] i,
    input  logic [79:0]       word,
    output logic [3:0]        opr,
    output logic [31:0]       cnst_re,
    output logic [31:0]       cnst_im,
    output logic              cnstA,
    output logic              cnstB,
    output logic              alu_start,
    output logic [1:0]        wr_addr,
    output logic              wr_enA,
    output logic              wr_enB,
    output logic              busy,
    output logic              done
);

    localparam int unsigned MAXCLK_W = 6;
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(LAST_ADDR);

    typedef struct packed {
        logic [63:0]         cnst;
        logic [3:0]          opr;
        logic [MAXCLK_W-1:0] maxclk;
        logic [1:0]          endwreg;
        logic                enreg_a;
        logic                enreg_b;
        logic                cnst_a;
        logic                cnst_b;
    } word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t              state;
    word_t               fields;
    logic [MAXCLK_W-1:0] maxclk_q;
    logic [MAXCLK_W-1:0] wait_cnt;
    logic                enreg_a_q;
    logic                enreg_b_q;

    assign fields = word_t'(word);

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            i         <= '0;
            opr       <= '0;
            cnst_re   <= '0;
            cnst_im   <= '0;
            cnstA     <= 1'b0;
            cnstB     <= 1'b0;
            wr_addr   <= '0;
            maxclk_q  <= '0;
            enreg_a_q <= 1'b0;
            enreg_b_q <= 1'b0;
            wait_cnt  <= '0;
            alu_start <= 1'b0;
            wr_enA    <= 1'b0;
            wr_enB    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            wr_enA    <= 1'b0;
            wr_enB    <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i     <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // A halt word leaves the previously latched fields untouched.
                    if (fields.opr == HALT_OPR) begin
                        state <= S_DONE;
                    end else begin
                        opr       <= fields.opr;
                        cnst_re   <= fields.cnst[63:32];
                        cnst_im   <= fields.cnst[31:0];
                        cnstA     <= fields.cnst_a;
                        cnstB     <= fields.cnst_b;
                        wr_addr   <= fields.endwreg;
                        maxclk_q  <= fields.maxclk;
                        enreg_a_q <= fields.enreg_a;
                        enreg_b_q <= fields.enreg_b;
                        alu_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= (maxclk_q == '0) ? MAXCLK_W'(1) : maxclk_q;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - MAXCLK_W'(1);
                    if (wait_cnt == MAXCLK_W'(1)) begin
                        wr_enA <= enreg_a_q;
                        wr_enB <= enreg_b_q;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i == LAST_I) begin
                        state <= S_DONE;
                    end else begin
`ifdef SEQ_SINGLE_STEP_EN
                        state <= S_PAUSE;
`else
                        i     <= i + ADDR_W'(1);
                        state <= S_FETCH;
`endif
                    end
                end
                S_DONE: begin
                    // done rises on the same edge busy falls, so the pulse lands in IDLE.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
`ifdef SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        i     <= i + ADDR_W'(1);
                        state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected ALU issues, writes and done
// pulses into a queue; a forked monitor pops and compares them as the DUT presents each event.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  i;
    logic [79:0] word;
    logic [3:0]  opr;
    logic [31:0] cnst_re;
    logic [31:0] cnst_im;
    logic        cnstA;
    logic        cnstB;
    logic        alu_start;
    logic [1:0]  wr_addr;
    logic        wr_enA;
    logic        wr_enB;
    logic        busy;
    logic        done;

    logic [79:0] bank [16];
    assign word = bank[i];

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clock     (clk),
        .reset     (reset),
        .start     (start),
`ifdef SEQ_SINGLE_STEP_EN
        .step      (1'b1),
`endif
        .i         (i),
        .word      (word),
        .opr       (opr),
        .cnst_re   (cnst_re),
        .cnst_im   (cnst_im),
        .cnstA     (cnstA),
        .cnstB     (cnstB),
        .alu_start (alu_start),
        .wr_addr   (wr_addr),
        .wr_enA    (wr_enA),
        .wr_enB    (wr_enB),
        .busy      (busy),
        .done      (done)
    );

    // kind: 0 = ALU issue, 1 = register write, 2 = done pulse
    typedef struct {
        int           kind;
        int           cyc;
        logic [127:0] pl;
    } exp_t;

    exp_t sb_q[$];
    int   alu_cyc_q[$];
    int   wr_cyc_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   alu_cnt  = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [79:0] mk(input logic [63:0] c, input logic [3:0] op,
                                       input logic [5:0] mc, input logic [1:0] wa,
                                       input logic ea, input logic eb,
                                       input logic ca, input logic cb);
        return {c, op, mc, wa, ea, eb, ca, cb};
    endfunction

    task automatic push(input int kind, input int c, input logic [127:0] pl);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.pl   = pl;
        sb_q.push_back(e);
    endtask

    // Expected events for words 0..n-1 of a run whose start was high in cycle t0.
    task automatic expect_run(input int t0, input int n, input bit with_done, output int t_next);
        int          t;
        int          m;
        logic [79:0] w;
        t = t0;
        for (int a = 0; a < n; a++) begin
            w = bank[a];
            if (w[15:12] == 4'hF) begin
                push(2, t + 3, 128'({4'(a), 1'b0}));
                t_next = t;
                return;
            end
            m = (w[11:6] == 6'd0) ? 1 : int'(w[11:6]);
            push(0, t + 2, 128'({4'(a), w[15:12], w[79:48], w[47:16], w[1], w[0]}));
            if (w[3] | w[2]) push(1, t + 3 + m, 128'({4'(a), w[5:4], w[3], w[2]}));
            if (a == 15 && with_done) push(2, t + 5 + m, 128'({4'(a), 1'b0}));
            t = t + 3 + m;
        end
        t_next = t;
    endtask

    task automatic sb_check(input int kind, input logic [127:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
            return;
        end
        e = sb_q.pop_front();
        chk("event_kind", 128'(kind), 128'(e.kind));
        chk("event_cycle", 128'(cyc), 128'(e.cyc));
        chk("event_payload", got, e.pl);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (alu_start) begin
                alu_cnt++;
                alu_cyc_q.push_back(cyc);
                sb_check(0, 128'({i, opr, cnst_re, cnst_im, cnstA, cnstB}));
            end
            if (wr_enA | wr_enB) begin
                wr_cnt++;
                wr_cyc_q.push_back(cyc);
                sb_check(1, 128'({i, wr_addr, wr_enA, wr_enB}));
            end
            if (done) begin
                done_cnt++;
                sb_check(2, 128'({i, busy}));
            end
        end
    endtask

    task automatic wait_done(input int limit);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(posedge clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        chk("done_within_budget", 128'(seen), 128'(1));
    endtask

    task automatic launch(input bit with_done, output int t0);
        int tn;
        @(posedge clk);
        #1;
        t0 = cyc;
        alu_cyc_q.delete();
        wr_cyc_q.delete();
        expect_run(t0, 16, with_done, tn);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int t0;
        int tn;
        int a0;
        int w0;
        int d0;
        int k;
        reset = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 16; a++) bank[a] = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 128'({i, opr, cnst_re, cnst_im, cnstA, cnstB, alu_start,
                                   wr_addr, wr_enA, wr_enB, busy, done}), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_without_start", 128'({busy, done, alu_start}), 128'(0));

        // Program A: basic word, long latency, zero latency, then a halt at word 3
        bank[0] = mk(64'd1232, 4'h0, 6'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        bank[1] = mk({32'hDEADBEEF, 32'h12345678}, 4'h9, 6'd38, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        bank[2] = mk({32'h0000_0007, 32'hFFFF_0000}, 4'h5, 6'd0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        bank[3] = mk(64'hA5A5_A5A5_5A5A_5A5A, 4'hF, 6'd5, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        a0 = alu_cnt;
        w0 = wr_cnt;
        launch(1'b1, t0);
        wait_done(400);
        @(negedge clk);
        chk("progA_write_count", 128'(wr_cnt - w0), 128'(3));
        chk("progA_alu_count", 128'(alu_cnt - a0), 128'(3));
        if (alu_cyc_q.size() >= 3 && wr_cyc_q.size() >= 3) begin
            chk("w0_alu_latency", 128'(alu_cyc_q[0] - t0), 128'(2));
            chk("w0_write_latency", 128'(wr_cyc_q[0] - t0), 128'(4));
            chk("w1_alu_to_write", 128'(wr_cyc_q[1] - alu_cyc_q[1]), 128'(39));
            chk("w2_alu_to_write", 128'(wr_cyc_q[2] - alu_cyc_q[2]), 128'(2));
        end
        chk("halt_i_busy", 128'({i, busy}), 128'({4'd3, 1'b0}));
        chk("halt_keeps_latched", 128'({opr, wr_addr, cnst_re}), 128'({4'h5, 2'd3, 32'h7}));
        chk("progA_drained", 128'(sb_q.size()), 128'(0));

        // Program B: 16 non-halting words (some zero-enable), start pulsed mid-run
        for (int a = 0; a < 16; a++)
            bank[a] = mk({32'(a * 3 + 1), 32'(a ^ 5)}, 4'(a % 9), 6'(a % 4), 2'(a % 4),
                         (a % 3) != 0, (a % 2) == 0, (a % 2) == 1, (a % 3) == 1);
        a0 = alu_cnt;
        d0 = done_cnt;
        launch(1'b1, t0);
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        chk("busy_mid_run", 128'(busy), 128'(1));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(600);
        @(negedge clk);
        chk("progB_alu_count", 128'(alu_cnt - a0), 128'(16));
        chk("progB_done_count", 128'(done_cnt - d0), 128'(1));
        chk("progB_end_i_busy", 128'({i, busy}), 128'({4'd15, 1'b0}));
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("progB_i_holds", 128'({i, busy, done}), 128'({4'd15, 1'b0, 1'b0}));
        chk("progB_drained", 128'(sb_q.size()), 128'(0));

        // Program C: reset during the WAIT of word 5
        bank[5] = mk({32'(16), 32'(0)}, 4'd5, 6'd20, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        a0 = alu_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        t0 = cyc;
        expect_run(t0, 5, 1'b0, tn);
        push(0, tn + 2, 128'({4'd5, bank[5][15:12], bank[5][79:48], bank[5][47:16],
                              bank[5][1], bank[5][0]}));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        while (alu_cnt - a0 < 6 && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk("word5_issued", 128'(alu_cnt - a0), 128'(6));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_state", 128'({i, busy, wr_enA, wr_enB, alu_start, opr}), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("mid_reset_write_count", 128'(wr_cnt - w0), 128'(4));
        chk("mid_reset_idle", 128'({i, busy}), 128'(0));
        chk("progC_drained", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
